posit_mul_seq: RTL and testbench
================================

POSIT_MUL_SEQ -- requirements
Module: posit_mul_seq

Interface
REQ-001 Parameter N, default 32, posit word width; SHALL match the upstream posit_extraction stage.
REQ-002 Parameter ES, default 2, exponent field width.
REQ-003 Parameter RS, default $clog2(N), regime-count width; k ports are RS+1 bits signed.
REQ-004 Local SW = RS+ES+3 SHALL be the signed scale width.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 in_valid  in  1  operand pair valid.
REQ-008 in_ready  out  1  block can accept an operand pair.
REQ-009 a_sign, b_sign  in  1  operand signs.
REQ-010 a_k, b_k  in  RS+1 signed  regime values.
REQ-011 a_exp, b_exp  in  ES  exponent fields.
REQ-012 a_mant, b_mant  in  N  mantissas, hidden 1 at bit N-1.
REQ-013 a_inf, b_inf, a_zero, b_zero  in  1  special-value flags.
REQ-014 out_valid  out  1  result valid.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 out_sign  out  1; out_scale  out  SW signed; out_mant  out  2N, normalized, MSB=1; out_inf, out_zero  out  1.

Function
REQ-017 Operand scale SHALL be k*2^ES + exp, sign-extended to SW; result scale = sum of both operand scales, plus the normalization increment.
REQ-018 FSM states SHALL be IDLE, MUL, NORM, DONE; in_ready=1 only in IDLE.
REQ-019 Accept SHALL occur on an edge where state is IDLE and in_valid=1; all operand fields SHALL be captured on that edge.
REQ-020 On accept with any inf or zero flag set, next state SHALL be DONE; otherwise next state SHALL be MUL with bit counter 0 and accumulator 0.
REQ-021 MUL SHALL perform one shift-add step per cycle over b_mant, LSB first, into a 2N-bit accumulator; after N MUL cycles state SHALL go to NORM.
REQ-022 NORM: if product bit 2N-1 = 1, out_mant = product and scale += 1; else out_mant = product << 1, scale unchanged. Next state SHALL be DONE.
REQ-023 Normal latency: out_valid SHALL be 1 exactly N+1 cycles after the accepting edge (33 for N=32).
REQ-024 Special latency: out_valid SHALL be 1 in the cycle right after the accepting edge.
REQ-025 Specials: any inf -> out_inf=1 and out_zero=0 (this covers inf*0). Else any zero -> out_zero=1. In both cases out_sign=0, out_scale=0, out_mant=0.
REQ-026 Normal results: out_sign = a_sign XOR b_sign; out_inf = out_zero = 0.
REQ-027 DONE holds out_valid=1 and all out_* stable until out_ready=1; that edge SHALL return the FSM to IDLE and clear out_valid.
REQ-028 No overlap: a new operand pair SHALL NOT be accepted in any state other than IDLE; in_valid outside IDLE SHALL be ignored.
REQ-029 All outputs SHALL be registered; out_* SHALL be driven only from the result registers.

Reset
REQ-030 rst=1 SHALL, without waiting for clk, force state IDLE, in_ready=1, out_valid=0, and all out_* data, flags, accumulator and counter to 0.
REQ-031 rst asserted during MUL, NORM or DONE SHALL discard the operation; no out_valid pulse SHALL follow the release of rst.

Verification
REQ-032 1.0*1.0: all k/exp=0, a_mant=b_mant=0x80000000 -> after 33 cycles out_mant=0x8000000000000000, out_scale=0, out_sign=0.
REQ-033 Carry: a_k=1, a_exp=2, b_k=-1, b_exp=1, both mant=0xC0000000, a_sign=1 -> out_mant=0x9000000000000000, out_scale=4, out_sign=1.
REQ-034 Specials: a_zero=1 -> out_zero=1 on the next cycle; a_inf=1 with b_zero=1 -> out_inf=1, out_zero=0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE the next cycle.
REQ-036 Reset at MUL cycle 10 -> in_ready=1 and out_valid=0 immediately; no stale result afterwards; the next operation completes correctly.

Source files
------------

// File: rtl/posit_mul_seq.sv
// Sequential posit mantissa multiplier: one shift-add step per cycle, then a single
// normalization step. Special operands (inf/zero) bypass the datapath.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready=1
// MUL   | N shift-add steps over b_mant, LSB first
// NORM  | align product MSB to bit 2N-1, adjust scale, load results
// DONE  | out_valid=1, results held until out_ready
module posit_mul_seq #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int RS = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  a_sign,
    input  logic                  b_sign,
    input  logic signed [RS:0]    a_k,
    input  logic signed [RS:0]    b_k,
    input  logic [ES-1:0]         a_exp,
    input  logic [ES-1:0]         b_exp,
    input  logic [N-1:0]          a_mant,
    input  logic [N-1:0]          b_mant,
    input  logic                  a_inf,
    input  logic                  b_inf,
    input  logic                  a_zero,
    input  logic                  b_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic signed [RS+ES+2:0] out_scale,
    output logic [2*N-1:0]        out_mant,
    output logic                  out_inf,
    output logic                  out_zero
);

    localparam int SW = RS + ES + 3;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     state_q,     state_d;
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic [2*N-1:0] acc_q,       acc_d;
    logic [2*N-1:0] mcand_q,     mcand_d;
    logic [N-1:0]   mplier_q,    mplier_d;
    logic [SW-1:0]  scale_q,     scale_d;
    logic           sign_q,      sign_d;
    logic           in_ready_q,  in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           out_sign_q,  out_sign_d;
    logic [SW-1:0]  out_scale_q, out_scale_d;
    logic [2*N-1:0] out_mant_q,  out_mant_d;
    logic           out_inf_q,   out_inf_d;
    logic           out_zero_q,  out_zero_d;

    // Operand scale = k*2^ES + exp; the low ES bits of k<<ES are zero, so OR adds exp.
    logic [SW-1:0] a_kx, b_kx, scale_a, scale_b;
    assign a_kx    = {{(SW-RS-1){a_k[RS]}}, a_k};
    assign b_kx    = {{(SW-RS-1){b_k[RS]}}, b_k};
    assign scale_a = (a_kx << ES) | {{(SW-ES){1'b0}}, a_exp};
    assign scale_b = (b_kx << ES) | {{(SW-ES){1'b0}}, b_exp};

    logic any_inf, any_zero;
    assign any_inf  = a_inf | b_inf;
    assign any_zero = a_zero | b_zero;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        scale_d     = scale_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_scale_d = out_scale_q;
        out_mant_d  = out_mant_q;
        out_inf_d   = out_inf_q;
        out_zero_d  = out_zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = a_sign ^ b_sign;
                    scale_d = scale_a + scale_b;
                    if (any_inf || any_zero) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_sign_d  = 1'b0;
                        out_scale_d = '0;
                        out_mant_d  = '0;
                        out_inf_d   = any_inf;
                        out_zero_d  = ~any_inf;
                    end else begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{N{1'b0}}, a_mant};
                        mplier_d = b_mant;
                    end
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // Product of two [1,2) mantissas lies in [1,4): at most one bit of shift.
                out_sign_d = sign_q;
                out_inf_d  = 1'b0;
                out_zero_d = 1'b0;
                if (acc_q[2*N-1]) begin
                    out_mant_d  = acc_q;
                    out_scale_d = scale_q + SW'(1);
                end else begin
                    out_mant_d  = acc_q << 1;
                    out_scale_d = scale_q;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            scale_q     <= '0;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_scale_q <= '0;
            out_mant_q  <= '0;
            out_inf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            scale_q     <= scale_d;
            sign_q      <= sign_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_scale_q <= out_scale_d;
            out_mant_q  <= out_mant_d;
            out_inf_q   <= out_inf_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_scale = out_scale_q;
    assign out_mant  = out_mant_q;
    assign out_inf   = out_inf_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_posit_mul_seq.sv
// Bench for posit_mul_seq: directed vector table, randomized ops against an arithmetic
// reference model, plus backpressure and mid-operation reset sequences.
module tb_posit_mul_seq;

    localparam int N  = 32;
    localparam int ES = 2;
    localparam int RS = 5;
    localparam int SW = RS + ES + 3;
    localparam int LAT_NORMAL = N + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready;
    logic                 a_sign, b_sign;
    logic signed [RS:0]   a_k, b_k;
    logic [ES-1:0]        a_exp, b_exp;
    logic [N-1:0]         a_mant, b_mant;
    logic                 a_inf, b_inf, a_zero, b_zero;
    logic                 out_valid, out_ready;
    logic                 out_sign;
    logic signed [SW-1:0] out_scale;
    logic [2*N-1:0]       out_mant;
    logic                 out_inf, out_zero;

    posit_mul_seq #(.N(N), .ES(ES), .RS(RS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .b_sign(b_sign),
        .a_k(a_k), .b_k(b_k),
        .a_exp(a_exp), .b_exp(b_exp),
        .a_mant(a_mant), .b_mant(b_mant),
        .a_inf(a_inf), .b_inf(b_inf), .a_zero(a_zero), .b_zero(b_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_scale(out_scale), .out_mant(out_mant),
        .out_inf(out_inf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                as, bs;
        logic signed [RS:0]  ak, bk;
        logic [ES-1:0]       ae, be;
        logic [N-1:0]        am, bm;
        logic                ai, bi, az, bz;
        logic                esign;
        logic [SW-1:0]       escale;
        logic [2*N-1:0]      emant;
        logic                einf, ezero;
        int                  elat;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // Reference: scales from k*2^ES+exp as integers, product by plain 64-bit multiply.
    function automatic vec_t model(input logic as, input logic bs, input int ak, input int bk,
                                   input int ae, input int be, input logic [N-1:0] am,
                                   input logic [N-1:0] bm, input logic ai, input logic bi,
                                   input logic az, input logic bz);
        vec_t v;
        logic [63:0] p;
        int sc;
        v.as = as; v.bs = bs; v.ak = (RS+1)'(ak); v.bk = (RS+1)'(bk);
        v.ae = ES'(ae); v.be = ES'(be); v.am = am; v.bm = bm;
        v.ai = ai; v.bi = bi; v.az = az; v.bz = bz;
        v.esign = 1'b0; v.escale = '0; v.emant = '0; v.einf = 1'b0; v.ezero = 1'b0;
        if (ai || bi) begin
            v.einf = 1'b1; v.elat = 0;
        end else if (az || bz) begin
            v.ezero = 1'b1; v.elat = 0;
        end else begin
            p  = {32'b0, am} * {32'b0, bm};
            sc = ak * (1 << ES) + ae + bk * (1 << ES) + be;
            if (p[63]) begin
                v.emant = p; sc = sc + 1;
            end else begin
                v.emant = p << 1;
            end
            v.escale = SW'(sc);
            v.esign  = as ^ bs;
            v.elat   = LAT_NORMAL;
        end
        return v;
    endfunction

    function automatic vec_t dir(input logic as, input logic bs, input int ak, input int bk,
                                 input int ae, input int be, input logic [N-1:0] am,
                                 input logic [N-1:0] bm, input logic ai, input logic bi,
                                 input logic az, input logic bz, input logic es,
                                 input logic [SW-1:0] esc, input logic [2*N-1:0] em,
                                 input logic ei, input logic ez, input int el);
        vec_t v;
        v.as = as; v.bs = bs; v.ak = (RS+1)'(ak); v.bk = (RS+1)'(bk);
        v.ae = ES'(ae); v.be = ES'(be); v.am = am; v.bm = bm;
        v.ai = ai; v.bi = bi; v.az = az; v.bz = bz;
        v.esign = es; v.escale = esc; v.emant = em; v.einf = ei; v.ezero = ez; v.elat = el;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        a_sign = v.as; b_sign = v.bs; a_k = v.ak; b_k = v.bk;
        a_exp = v.ae; b_exp = v.be; a_mant = v.am; b_mant = v.bm;
        a_inf = v.ai; b_inf = v.bi; a_zero = v.az; b_zero = v.bz;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0;
        a_sign = 1'b0; b_sign = 1'b0; a_k = '0; b_k = '0; a_exp = '0; b_exp = '0;
        a_mant = '0; b_mant = '0; a_inf = 1'b0; b_inf = 1'b0; a_zero = 1'b0; b_zero = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        logic [SW-1:0] sc;
        sc = out_scale;
        chk(tag, "out_sign",  64'(out_sign),  64'(v.esign));
        chk(tag, "out_scale", 64'(sc),        64'(v.escale));
        chk(tag, "out_mant",  out_mant,       v.emant);
        chk(tag, "out_inf",   64'(out_inf),   64'(v.einf));
        chk(tag, "out_zero",  64'(out_zero),  64'(v.ezero));
    endtask

    // Entered just after a rising edge with the DUT idle and out_ready=1.
    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        drive(v);
        in_valid = 1'b1;
        chk(tag, "in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        clear_inputs();
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(tag, "latency", 64'(lat), 64'(v.elat));
        check_outputs(tag, v);
        @(posedge clk); #1;
        chk(tag, "back_idle", 64'({out_valid, in_ready}), 64'b01);
    endtask

    vec_t tbl[8];
    vec_t v, vb;
    int   stray;

    initial begin
        clear_inputs();
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("reset", "in_ready",  64'(in_ready),  64'd1);
        chk("reset", "out_valid", 64'(out_valid), 64'd0);
        chk("reset", "out_mant",  out_mant,       64'd0);
        chk("reset", "flags",     64'({out_sign, out_inf, out_zero}), 64'd0);
        chk("reset", "out_scale", 64'(SW'(out_scale)), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        //              as  bs  ak  bk  ae be am            bm            ai bi az bz  es  escale    emant                   ei ez lat
        tbl[0] = dir(0, 0,  0,  0, 0, 0, 32'h80000000, 32'h80000000, 0, 0, 0, 0,  0, 10'd0,   64'h8000000000000000, 0, 0, LAT_NORMAL);
        tbl[1] = dir(1, 0,  1, -1, 2, 1, 32'hC0000000, 32'hC0000000, 0, 0, 0, 0,  1, 10'd4,   64'h9000000000000000, 0, 0, LAT_NORMAL);
        tbl[2] = dir(1, 0,  3,  2, 1, 1, 32'h80000000, 32'hA0000000, 0, 0, 1, 0,  0, 10'd0,   64'h0,                0, 1, 0);
        tbl[3] = dir(0, 1,  0,  0, 0, 0, 32'h80000000, 32'h80000000, 1, 0, 0, 1,  0, 10'd0,   64'h0,                1, 0, 0);
        tbl[4] = dir(1, 0, -2,  4, 3, 0, 32'hF0000000, 32'h90000000, 0, 1, 0, 0,  0, 10'd0,   64'h0,                1, 0, 0);
        tbl[5] = dir(1, 1,  5,  5, 0, 0, 32'h80000000, 32'h80000000, 0, 0, 0, 1,  0, 10'd0,   64'h0,                0, 1, 0);
        tbl[6] = dir(0, 1, -3, -2, 1, 3, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0,  1, 10'h3F0,  64'hFFFFFFFF00000000, 0, 0, LAT_NORMAL);
        tbl[7] = dir(1, 1,  2,  0, 3, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0,  0, 10'd12,  64'hFFFFFFFE00000001, 0, 0, LAT_NORMAL);
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        for (int i = 0; i < 30; i++) begin
            logic [N-1:0] ma, mb;
            int r;
            ma = $urandom() | 32'h80000000;
            mb = $urandom() | 32'h80000000;
            r  = int'($urandom_range(0, 19));
            v = model(1'($urandom()), 1'($urandom()),
                      int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 60)) - 30,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ma, mb,
                      r == 0, r == 1, r == 2 || r == 4, r == 3 || r == 4);
            run_vec($sformatf("rnd%0d", i), v);
        end

        // Backpressure: results held in DONE while in_valid is ignored.
        vb = model(1, 0, 4, -5, 2, 3, 32'hB504F334, 32'hD1234567, 0, 0, 0, 0);
        out_ready = 1'b0;
        drive(vb);
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        stray = 0;
        while (out_valid !== 1'b1 && stray < 200) begin
            @(posedge clk); #1;
            stray++;
        end
        chk("bp", "latency", 64'(stray), 64'(LAT_NORMAL));
        for (int c = 0; c < 5; c++) begin
            v = model(0, 0, 1, 1, 0, 0, 32'h80000000, 32'h80000000, 0, 0, c == 2, 0);
            drive(v);
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("bp%0d", c), "out_valid", 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d", c), "in_ready",  64'(in_ready),  64'd0);
            check_outputs($sformatf("bp%0d", c), vb);
        end
        clear_inputs();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp", "released", 64'({out_valid, in_ready}), 64'b01);
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) stray++;
        end
        chk("bp", "no_ghost_op", 64'(stray), 64'd0);

        // Reset in the middle of MUL discards the operation.
        v = model(0, 1, 2, 3, 1, 2, 32'hE0000000, 32'hC8000000, 0, 0, 0, 0);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        chk("rst", "busy_in_mul", 64'({out_valid, in_ready}), 64'b00);
        #2;
        rst = 1'b1;
        #1;
        chk("rst", "in_ready_async",  64'(in_ready),  64'd1);
        chk("rst", "out_valid_async", 64'(out_valid), 64'd0);
        chk("rst", "out_mant_async",  out_mant,       64'd0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) stray++;
        end
        chk("rst", "no_stale_result", 64'(stray), 64'd0);
        chk("rst", "idle_after", 64'(in_ready), 64'd1);
        v = model(1, 1, -1, 2, 3, 2, 32'hAAAAAAAA, 32'h87654321, 0, 0, 0, 0);
        run_vec("after_rst", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
